// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data_mem_bank slice: state encoding,
// geometry helpers, byte merge and per-byte parity.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Helpers operate on a fixed maximum width; callers cast to their own width.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return m;
    endfunction

    // Even parity: the stored bit makes the 9-bit group have an even count of ones.
    function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] w);
        logic [MAX_BYTES-1:0] p;
        for (int i = 0; i < MAX_BYTES; i++) begin
            p[i] = ^w[i*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset clear sequencer: walks every word index once in CLEAR, then
// parks in RUN and raises done.
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = dmem_pkg::idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx,
    output logic             done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
            else                            cnt_d   = cnt_q + 1'b1;
        end
        done_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign clr_we  = (state_q == CLEAR);
    assign clr_idx = cnt_q;
    assign done    = done_q;

endmodule

// File: rtl/data_mem_bank.sv
// Multi-read-port byte-addressed data memory with write forwarding and a
// post-reset clear. Define DMEM_PARITY_EN for per-byte parity and rd_par_err.
module data_mem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_BYTES_LOG2 = 2,
    parameter int DEPTH           = 1024,
    parameter int NUM_RD_PORTS    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [DATA_WIDTH/8-1:0]            wr_be,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid,
    output logic                               ready,
    output logic                               addr_err
`ifdef DMEM_PARITY_EN
    ,
    output logic [NUM_RD_PORTS-1:0]            rd_par_err
`endif
);

    localparam int BPW    = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int WIDX_W = ADDR_WIDTH - WORD_BYTES_LOG2;
    localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef DMEM_PARITY_EN
    logic [BPW-1:0]        par_q [DEPTH];
`endif

    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;
    logic             running;

    dmem_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .done    (running)
    );

    assign ready = running;

    // Byte-offset bits are deliberately ignored; only aligned words are supported.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr, rd_addr};

    logic [WIDX_W-1:0]     wr_widx;
    logic                  wr_in, wr_ok, mem_we;
    logic [DATA_WIDTH-1:0] wr_merged, mem_wdata;
    logic [IDX_W-1:0]      mem_idx;

    always_comb begin
        wr_widx   = wr_addr[ADDR_WIDTH-1:WORD_BYTES_LOG2];
        wr_in     = (wr_widx < DEPTH_W);
        wr_ok     = running && wr_en && wr_in;
        wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_W'(mem_q[IDX_W'(wr_widx)]),
                                           MAX_DATA_W'(wr_data), MAX_BYTES'(wr_be)));
        mem_we    = clr_we || wr_ok;
        mem_idx   = clr_we ? clr_idx : IDX_W'(wr_widx);
        mem_wdata = clr_we ? '0 : wr_merged;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
`ifdef DMEM_PARITY_EN
            par_q[mem_idx] <= BPW'(byte_parity(MAX_DATA_W'(mem_wdata)));
`endif
        end
    end

    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD_PORTS-1:0]            rd_valid_q, rd_valid_d;
    logic                               addr_err_q, addr_err_d;
    logic [NUM_RD_PORTS-1:0]            rd_par_err_q, rd_par_err_d;
    logic [WIDX_W-1:0]                  rd_widx;
    logic                               rd_fire, rd_in, rd_fwd, rd_err_any;
    logic [DATA_WIDTH-1:0]              rd_word;

    // Each port sees the post-write word when it targets the word being written.
    always_comb begin
        rd_data_d    = rd_data_q;
        rd_valid_d   = '0;
        rd_par_err_d = '0;
        rd_err_any   = 1'b0;
        rd_widx      = '0;
        rd_fire      = 1'b0;
        rd_in        = 1'b0;
        rd_fwd       = 1'b0;
        rd_word      = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_widx = rd_addr[p*ADDR_WIDTH + WORD_BYTES_LOG2 +: WIDX_W];
            rd_fire = running && rd_en[p];
            rd_in   = (rd_widx < DEPTH_W);
            rd_fwd  = wr_ok && (wr_widx == rd_widx);
            if (!rd_in)      rd_word = '0;
            else if (rd_fwd) rd_word = wr_merged;
            else             rd_word = mem_q[IDX_W'(rd_widx)];
            if (rd_fire) rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_word;
            rd_valid_d[p] = rd_fire;
            rd_err_any    = rd_err_any || (rd_fire && !rd_in);
`ifdef DMEM_PARITY_EN
            rd_par_err_d[p] = rd_fire && rd_in && !rd_fwd &&
                              (BPW'(byte_parity(MAX_DATA_W'(rd_word))) != par_q[IDX_W'(rd_widx)]);
`endif
        end
        addr_err_d = rd_err_any || (running && wr_en && !wr_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            addr_err_q   <= 1'b0;
            rd_par_err_q <= '0;
        end else begin
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            addr_err_q   <= addr_err_d;
            rd_par_err_q <= rd_par_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
`ifdef DMEM_PARITY_EN
    assign rd_par_err = rd_par_err_q;
`else
    logic unused_par;
    assign unused_par = ^rd_par_err_q;
`endif

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank (DEPTH=16, two read ports); parity checks
// are included when DMEM_PARITY_EN is defined.
module tb_data_mem_bank;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NP  = 2;
    localparam int DEP = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [3:0]     wr_be;
    logic [NP-1:0]  rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]  rd_valid;
    logic           ready;
    logic           addr_err;
`ifdef DMEM_PARITY_EN
    logic [NP-1:0]  rd_par_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_bank #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .WORD_BYTES_LOG2 (2),
        .DEPTH           (DEP),
        .NUM_RD_PORTS    (NP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ready    (ready),
        .addr_err (addr_err)
`ifdef DMEM_PARITY_EN
        ,
        .rd_par_err (rd_par_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        wr_be = 4'b0000;
        rd_en = '0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    task automatic read2(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    // Counts ready-low samples from the current one; bounded so a stuck sequencer still ends.
    task automatic wait_clear(input string tag);
        int   low   = 0;
        logic noisy = 1'b0;
        while (!ready && low < 40) begin
            if (rd_valid != '0 || addr_err) noisy = 1'b1;
            low++;
            tick();
        end
        check_eq({tag, "_ready_low_cycles"}, 64'(low), 64'd16);
        check_eq({tag, "_quiet_during_clear"}, 64'(noisy), 64'd0);
        check_eq({tag, "_ready_high"}, 64'(ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        idle();
        tick();
        tick();
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        check_eq("rst_addr_err", 64'(addr_err), 64'd0);
        reset = 1'b0;
        wait_clear("init");

        // Every word reads back zero after the clear, on both ports.
        for (int w = 0; w < DEP; w++) begin
            read2(2'b11, 32'(w * 4), 32'(w * 4));
            tick();
            check_eq($sformatf("clr_valid_w%0d", w), 64'(rd_valid), 64'h3);
            check_eq($sformatf("clr_data_w%0d", w), 64'(rd_data), 64'h0);
        end
        idle();

        // Byte-enable merge.
        write(32'h10, 32'hAABBCCDD, 4'b1111);
        tick();
        write(32'h10, 32'h11223344, 4'b0101);
        tick();
        idle();
        read2(2'b11, 32'h10, 32'h14);
        tick();
        check_eq("merge_p0", 64'(rd_data[31:0]), 64'hAA22CC44);
        check_eq("unwritten_p1", 64'(rd_data[63:32]), 64'h0);
        check_eq("merge_valid", 64'(rd_valid), 64'h3);

        // Same-cycle write and read forwards the new word to both ports.
        idle();
        write(32'h20, 32'hDEADBEEF, 4'b1111);
        read2(2'b11, 32'h20, 32'h20);
        tick();
        check_eq("fwd_data", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);
        check_eq("fwd_valid", 64'(rd_valid), 64'h3);

        // Idle ports hold their data with valid low.
        idle();
        tick();
        check_eq("hold_valid", 64'(rd_valid), 64'h0);
        check_eq("hold_data", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);

        // Out-of-range write and port-1 read.
        write(32'h40, 32'hFFFFFFFF, 4'b1111);
        read2(2'b10, 32'h0, 32'h44);
        tick();
        check_eq("oor_addr_err", 64'(addr_err), 64'd1);
        check_eq("oor_valid", 64'(rd_valid), 64'h2);
        check_eq("oor_data", 64'(rd_data), 64'h00000000_DEADBEEF);
        idle();
        read2(2'b01, 32'h0, 32'h0);
        tick();
        check_eq("oor_pulse_once", 64'(addr_err), 64'd0);
        check_eq("oor_no_alias_w0", 64'(rd_data[31:0]), 64'h0);

        // Several out-of-range accesses in one cycle give one pulse.
        write(32'h7C, 32'h5A5A5A5A, 4'b1111);
        read2(2'b11, 32'h48, 32'h4C);
        tick();
        check_eq("multi_err_pulse", 64'(addr_err), 64'd1);
        check_eq("multi_err_data", 64'(rd_data), 64'h0);
        idle();
        tick();
        check_eq("multi_err_single", 64'(addr_err), 64'd0);

        // Reset in RUN and again mid-CLEAR restarts a full clear.
        write(32'h8, 32'h12345678, 4'b1111);
        tick();
        idle();
        read2(2'b01, 32'h8, 32'h0);
        tick();
        check_eq("pre_reset_w2", 64'(rd_data[31:0]), 64'h12345678);
        idle();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_eq("run_rst_rd_data", 64'(rd_data), 64'h0);
        reset = 1'b0;
        write(32'h8, 32'hFFFFFFFF, 4'b1111);
        read2(2'b11, 32'h8, 32'h8);
        repeat (5) tick();
        check_eq("mid_clear_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear("restart");
        idle();
        read2(2'b11, 32'h8, 32'h8);
        tick();
        check_eq("post_clear_w2", 64'(rd_data), 64'h0);
        check_eq("post_clear_valid", 64'(rd_valid), 64'h3);

`ifdef DMEM_PARITY_EN
        idle();
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        read2(2'b11, 32'hC, 32'h4);
        tick();
        check_eq("par_err", 64'(rd_par_err), 64'h1);
        check_eq("par_valid", 64'(rd_valid), 64'h3);
        idle();
        write(32'hC, 32'h0000000F, 4'b0001);
        read2(2'b01, 32'hC, 32'h0);
        tick();
        check_eq("par_fwd_clean", 64'(rd_par_err), 64'h0);
`endif

        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
